// File: rtl/sysmon_pkg.sv
// Shared types and constants for the SYSMON DRP scheduler: FSM states, DRP owners,
// auto-sequence channel indices and the data reported to the host on a DRP timeout.
package sysmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    CAP  = 1'b0,
    HOST = 1'b1
  } owner_e;

  localparam logic [4:0]  CH_TEMP        = 5'd0;
  localparam logic [4:0]  CH_VCCINT      = 5'd1;
  localparam logic [4:0]  CH_VCCAUX      = 5'd2;
  localparam logic [4:0]  CH_VP          = 5'd3;
  localparam logic [15:0] DRP_ABORT_DATA = 16'hDEAD;

endpackage

// File: rtl/sysmon_drp_sched_if.sv
// Host command bus from the PicoBus decoder, and the SYSMON DRP/sequencer pins.
interface sysmon_host_if;
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_err;

  modport master (output host_req, host_we, host_addr, host_wdata,
                  input  host_ack, host_rdata, host_err);
  modport slave  (input  host_req, host_we, host_addr, host_wdata,
                  output host_ack, host_rdata, host_err);
endinterface

interface sysmon_drp_if;
  logic        sm_den;
  logic        sm_dwe;
  logic [6:0]  sm_daddr;
  logic [15:0] sm_di;
  logic        sm_drdy;
  logic [15:0] sm_do;
  logic        sm_eoc;
  logic [4:0]  sm_channel;

  modport master (output sm_den, sm_dwe, sm_daddr, sm_di,
                  input  sm_drdy, sm_do, sm_eoc, sm_channel);
  modport slave  (input  sm_den, sm_dwe, sm_daddr, sm_di,
                  output sm_drdy, sm_do, sm_eoc, sm_channel);
endinterface

// File: rtl/sysmon_eoc_latch.sv
// Single-entry pending-EOC latch with overrun detection. A fresh EOC is visible to the
// scheduler in the same cycle, so a simultaneous host request cannot overtake it.
module sysmon_eoc_latch (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       eoc_i,
  input  logic [4:0] ch_i,
  input  logic       grant_i,
  output logic       pend_o,
  output logic [4:0] pend_ch_o,
  output logic       overrun_o
);

  logic       pend_q, pend_d;
  logic [4:0] ch_q, ch_d;

  assign pend_o    = pend_q | eoc_i;
  assign pend_ch_o = pend_q ? ch_q : ch_i;
  assign overrun_o = eoc_i & pend_q & ~grant_i;

  always_comb begin
    pend_d = pend_q;
    ch_d   = ch_q;
    if (grant_i) pend_d = 1'b0;
    // A granted EOC that bypassed an empty latch must not be stored again.
    if (eoc_i && !(grant_i && !pend_q)) begin
      pend_d = 1'b1;
      ch_d   = ch_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ch_q   <= ch_d;
    end
  end

endmodule

// File: rtl/sysmon_drp_sched.sv
// Sole owner of the SYSMON DRP: arbitrates EOC-triggered sample captures (priority)
// against host read/write commands, one outstanding transaction, DRDY timeout recovery.
module sysmon_drp_sched
  import sysmon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         PicoClk,
  input  logic         PicoRst_n,
  sysmon_host_if.slave host,
  sysmon_drp_if.master drp,
  output logic [9:0]   temp,
  output logic [9:0]   vccint,
  output logic [9:0]   vccaux,
  output logic [9:0]   vp,
  output logic [3:0]   upd,
  input  logic         clr_status,
  output logic         eoc_overrun,
  output logic         drp_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [3:0][9:0]   samp_q, samp_d;
  logic [3:0]        upd_q, upd_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;

  logic              grant_cap;
  logic              abort;
  logic              pend_vld;
  logic [4:0]        pend_ch;
  logic              ovr_evt;

  sysmon_eoc_latch u_eoc_latch (
    .clk_i     (PicoClk),
    .rst_ni    (PicoRst_n),
    .eoc_i     (drp.sm_eoc),
    .ch_i      (drp.sm_channel),
    .grant_i   (grant_cap),
    .pend_o    (pend_vld),
    .pend_ch_o (pend_ch),
    .overrun_o (ovr_evt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    den_d     = 1'b0;
    dwe_d     = dwe_q;
    daddr_d   = daddr_q;
    di_d      = di_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    samp_d    = samp_q;
    upd_d     = '0;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    grant_cap = 1'b0;
    abort     = 1'b0;

    // Clear first so a same-cycle set event overrides it.
    if (clr_status) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ovr_evt) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (pend_vld) begin
          grant_cap = 1'b1;
          owner_d   = CAP;
          daddr_d   = {2'b00, pend_ch};
          dwe_d     = 1'b0;
          di_d      = '0;
          den_d     = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
        end else if (host.host_req) begin
          owner_d   = HOST;
          daddr_d   = host.host_addr;
          dwe_d     = host.host_we;
          di_d      = host.host_wdata;
          den_d     = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (drp.sm_drdy || cnt_q == CNT_LAST) begin
          abort   = ~drp.sm_drdy;
          state_d = DONE;
          if (abort) tmo_d = 1'b1;
          if (owner_q == HOST) begin
            ack_d   = 1'b1;
            err_d   = abort;
            rdata_d = abort ? DRP_ABORT_DATA : (dwe_q ? 16'h0000 : drp.sm_do);
          end else if (!abort) begin
            case (daddr_q[4:0])
              CH_TEMP:   begin samp_d[0] = drp.sm_do[15:6]; upd_d[0] = 1'b1; end
              CH_VCCINT: begin samp_d[1] = drp.sm_do[15:6]; upd_d[1] = 1'b1; end
              CH_VCCAUX: begin samp_d[2] = drp.sm_do[15:6]; upd_d[2] = 1'b1; end
              CH_VP:     begin samp_d[3] = drp.sm_do[15:6]; upd_d[3] = 1'b1; end
              default:   ;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      state_q <= IDLE;
      owner_q <= CAP;
      cnt_q   <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      samp_q  <= '0;
      upd_q   <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      samp_q  <= samp_d;
      upd_q   <= upd_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign drp.sm_den      = den_q;
  assign drp.sm_dwe      = dwe_q;
  assign drp.sm_daddr    = daddr_q;
  assign drp.sm_di       = di_q;
  assign host.host_ack   = ack_q;
  assign host.host_err   = err_q;
  assign host.host_rdata = rdata_q;
  assign temp            = samp_q[0];
  assign vccint          = samp_q[1];
  assign vccaux          = samp_q[2];
  assign vp              = samp_q[3];
  assign upd             = upd_q;
  assign eoc_overrun     = ovr_q;
  assign drp_timeout     = tmo_q;

endmodule

// File: doc/sysmon_drp_sched.md
Name: sysmon_drp_sched

Overview:
- Single owner of the SYSMON dynamic reconfiguration port (DRP), with DCLK driven directly by PicoClk.
- Schedules two requesters: auto-sequence capture reads, triggered by EOC, and host DRP read/write commands forwarded from the PicoBus register decoder.
- Keeps the latest 10-bit temperature, Vccint, Vccaux and Vp samples. Recovers from a DRP that never returns DRDY by timing out.

Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for DRDY after DEN before aborting.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- PicoClk  in  1  sole clock; also drives SYSMON DCLK.
- PicoRst_n  in  1  asynchronous active-low reset.
- host_req  in  1  level request; host_we/host_addr/host_wdata are held stable until host_ack.
- host_we  in  1  1 = DRP write, 0 = DRP read.
- host_addr  in  7  DRP address.
- host_wdata  in  16  DRP write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  read data, valid with host_ack.
- host_err  out  1  valid with host_ack; 1 = timeout.
- sm_eoc  in  1  SYSMON end-of-conversion pulse.
- sm_channel  in  5  SYSMON CHANNEL output.
- sm_drdy  in  1  SYSMON DRDY.
- sm_do  in  16  SYSMON DO.
- sm_den  out  1  SYSMON DEN.
- sm_dwe  out  1  SYSMON DWE.
- sm_daddr  out  7  SYSMON DADDR.
- sm_di  out  16  SYSMON DI.
- temp, vccint, vccaux, vp  out  10 each  latest samples.
- upd  out  4  one-cycle update pulses; bit order {vp, vccaux, vccint, temp}.
- clr_status  in  1  clears the sticky status bits.
- eoc_overrun  out  1  sticky: an EOC was lost.
- drp_timeout  out  1  sticky: a timeout occurred on any owner.

Behaviour:
- Reset: every output is 0, FSM is IDLE, the pending-EOC latch is empty. Reset mid-transaction drops the transaction; no host_ack is issued.
- EOC latch: sm_eoc=1 loads pend_ch <= sm_channel and sets pend=1.
  - If pend is already 1 and has not been granted in this cycle, set eoc_overrun; the newest channel overwrites pend_ch.
  - The latch accepts a new EOC in the same cycle that it is granted.
- FSM IDLE:
  - If pend=1, grant capture: owner=CAP, sm_daddr={2'b0,pend_ch}, sm_dwe=0, clear pend.
  - Otherwise, if host_req=1, grant host: owner=HOST, sm_daddr=host_addr, sm_dwe=host_we, sm_di=host_wdata.
  - Capture always has priority over host.
  - On grant, sm_den=1 for exactly the next cycle (registered). Go to WAIT and clear the counter.
- FSM WAIT:
  - sm_den=0. The counter increments each cycle.
  - If sm_drdy=1, complete. If DRDY and timeout coincide, DRDY wins.
  - If the counter reaches TIMEOUT_CYCLES-1 without DRDY, abort and set drp_timeout.
  - Go to DONE in both cases.
- DRDY seen while in IDLE or DONE is ignored.
- Completion, owner CAP: if sm_channel index is 0..3, write sm_do[15:6] to temp/vccint/vccaux/vp respectively and pulse the matching upd bit in DONE. Index ≥4 is discarded; capture aborts update nothing.
- Completion, owner HOST: in DONE, host_ack=1 and host_err=abort. host_rdata=sm_do on a read, 16'h0 on a write, 16'hDEAD on an abort.
- FSM DONE: one cycle, then IDLE. The host drops host_req in the cycle host_ack is high; a req still high in the next IDLE cycle is treated as a new request.
- Host read latency: req seen in IDLE at cycle 0, DEN at cycle 1, DRDY at cycle k (k≥2), host_ack at cycle k+1.
- Only one DRP transaction is ever outstanding.
- clr_status clears eoc_overrun and drp_timeout. If a set event occurs in the same cycle, set wins.

Decomposition:
- Shared package sysmon_pkg holds:
  - state encoding IDLE/WAIT/DONE
  - owner encoding CAP/HOST
  - channel constants CH_TEMP=0, CH_VCCINT=1, CH_VCCAUX=2, CH_VP=3
  - DRP_ABORT_DATA=16'hDEAD
- One natural sub-module, sysmon_eoc_latch, containing the pending-EOC register and the overrun detect.

Test Plan:
- EOC ch0, DRDY 3 cycles after DEN, DO=16'hA5C0 -> temp=10'h297, upd=4'b0001 for one cycle, no host_ack.
- Host read addr 7'h40, DRDY with DO=16'h3000 -> one DEN pulse with DWE=0, DADDR=7'h40; host_ack with rdata=16'h3000 and err=0, one cycle after DRDY.
- host_req and EOC ch2 arrive in the same IDLE cycle -> capture issued first, vccaux updated; host DEN issued after the capture's DONE; host_ack follows the second DRDY.
- Host write addr 7'h41, data 16'h20FE, no DRDY -> sm_di=16'h20FE, DWE=1; host_ack with err=1 and rdata=16'hDEAD after TIMEOUT_CYCLES; drp_timeout=1, then cleared by clr_status.
- Three EOCs (ch1, ch2, ch3) while the FSM is in WAIT -> eoc_overrun=1; only ch3 captured next; vccint and vccaux unchanged.
- PicoRst_n asserted during WAIT of a host read -> all outputs 0 immediately; no host_ack; the next request completes normally.
